// File: rtl/filter2d_pkg.sv
// Shared definitions for the 2-D filter: sequencer states, tap count and the
// default 3x3 kernel that both the filter core and its sequencer reset to.
package filter2d_pkg;

  localparam int N_TAPS = 9;

  localparam logic [7:0] COEF_CORNER = 8'h08;
  localparam logic [7:0] COEF_EDGE   = 8'h10;
  localparam logic [7:0] COEF_CENTER = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  // Binomial smoothing kernel, row-major: corners, edges, centre.
  function automatic logic [7:0] default_coef(input logic [3:0] idx);
    logic [7:0] coef;
    case (idx)
      4'd0, 4'd2, 4'd6, 4'd8: coef = COEF_CORNER;
      4'd1, 4'd3, 4'd5, 4'd7: coef = COEF_EDGE;
      4'd4:                   coef = COEF_CENTER;
      default:                coef = 8'h00;
    endcase
    return coef;
  endfunction

endpackage

// File: rtl/filter2d_watchdog.sv
// Loadable cycle counter; flags when the next idle cycle would reach TIMEOUT.
module filter2d_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic n_reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  logic [15:0] count;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !timeout) begin
      count <= count + 16'd1;
    end
  end

  assign timeout = (count == 16'(TIMEOUT - 1));

endmodule

// File: rtl/filter2d_ctrl.sv
// Frame sequencer for filter2d_op: downloads the shadow kernel, starts the
// filter and streams its result strobes into the output frame buffer.
module filter2d_ctrl
  import filter2d_pkg::*;
#(
  parameter int WIDTH   = 256,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_idx,
  input  logic [7:0]  cfg_data,
  input  logic        go,
  input  logic        err_clr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        f_start,
  output logic        f_h_write,
  output logic [3:0]  f_h_idx,
  output logic [7:0]  f_h_data,
  input  logic        f_o_strb,
  input  logic [7:0]  f_o_data,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data
);

  // 17 bits so a 256x256 frame (65536 pixels) still has a reachable terminal count.
  localparam logic [16:0] FRAME_PIXELS = 17'(WIDTH * WIDTH);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  shadow [N_TAPS];
  logic [3:0]  load_cnt;
  logic [16:0] pix_cnt;
  logic        run_strb;
  logic        last_pix;
  logic        cfg_ok;
  logic        wd_clear;
  logic        wd_timeout;

  assign run_strb = (state == S_RUN) && f_o_strb;
  assign last_pix = ((pix_cnt + 17'd1) == FRAME_PIXELS);
  assign cfg_ok   = cfg_we && (cfg_idx < 4'(N_TAPS)) &&
                    ((state == S_IDLE) || (state == S_ERR));
  assign wd_clear = (state == S_START) || run_strb;

  filter2d_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .n_reset (n_reset),
    .clear   (wd_clear),
    .enable  (state == S_RUN),
    .timeout (wd_timeout)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < N_TAPS; i++) begin
        shadow[i] <= default_coef(4'(i));
      end
    end else if (cfg_ok) begin
      shadow[cfg_idx] <= cfg_data;
    end
  end

  // A strobe arriving on the timeout cycle still counts and keeps the frame alive.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (go) state_nxt = S_LOAD;
      S_LOAD:  if (load_cnt == 4'(N_TAPS - 1)) state_nxt = S_START;
      S_START: state_nxt = S_RUN;
      S_RUN: begin
        if (f_o_strb) begin
          if (last_pix) state_nxt = S_DONE;
        end else if (wd_timeout) begin
          state_nxt = S_ERR;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   if (err_clr) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= S_IDLE;
      load_cnt  <= '0;
      pix_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      f_start   <= 1'b0;
      f_h_write <= 1'b0;
      f_h_idx   <= '0;
      f_h_data  <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      state     <= state_nxt;
      busy      <= state_nxt inside {S_LOAD, S_START, S_RUN};
      err       <= (state_nxt == S_ERR);
      done      <= run_strb && last_pix;
      f_start   <= (state == S_START);
      f_h_write <= (state == S_LOAD);
      f_h_idx   <= (state == S_LOAD) ? load_cnt : 4'd0;
      f_h_data  <= (state == S_LOAD) ? shadow[load_cnt] : 8'd0;
      load_cnt  <= (state == S_LOAD) ? load_cnt + 4'd1 : 4'd0;
      wr_en     <= run_strb;
      if (state == S_START) begin
        pix_cnt <= '0;
      end else if (run_strb) begin
        pix_cnt <= pix_cnt + 17'd1;
        wr_addr <= pix_cnt[15:0];
        wr_data <= f_o_data;
      end
    end
  end

endmodule

// File: tb/tb_filter2d_ctrl.sv
// Randomised directed bench for filter2d_ctrl with a behavioural filter model
// and an event log compared against a cycle-level expectation of each frame.
module tb_filter2d_ctrl;

  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int N_PIX   = WIDTH * WIDTH;
  localparam int BUDGET  = 4000;

  typedef struct {
    int          cyc;
    logic [15:0] a;
    logic [7:0]  d;
  } ev_t;

  logic        clk = 1'b0;
  logic        n_reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_idx = '0;
  logic [7:0]  cfg_data = '0;
  logic        go = 1'b0;
  logic        err_clr = 1'b0;
  logic        f_o_strb = 1'b0;
  logic [7:0]  f_o_data = '0;
  logic        busy, done, err, f_start, f_h_write, wr_en;
  logic [3:0]  f_h_idx;
  logic [7:0]  f_h_data, wr_data;
  logic [15:0] wr_addr;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [7:0] coef [9];
  ev_t hw_q[$];
  ev_t wr_q[$];
  ev_t exp_q[$];
  int  start_q[$];
  int  done_q[$];
  int  err_rise = -1;
  logic err_prev = 1'b0;
  logic busy_prev = 1'b0;
  logic busy_at_done = 1'b0;
  logic busy_before_done = 1'b0;

  int period = 12;
  int limit = N_PIX;
  int gap = 0;
  int sent = 0;
  bit active = 1'b0;
  bit stray_req = 1'b0;
  bit stray_after = 1'b0;
  bit stray_pending = 1'b0;

  filter2d_ctrl #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_data  (cfg_data),
    .go        (go),
    .err_clr   (err_clr),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .f_start   (f_start),
    .f_h_write (f_h_write),
    .f_h_idx   (f_h_idx),
    .f_h_data  (f_h_data),
    .f_o_strb  (f_o_strb),
    .f_o_data  (f_o_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Filter stand-in: after each start it emits `limit` strobes, one every `period` cycles.
  always @(posedge clk) begin
    #1;
    f_o_strb = 1'b0;
    if (!n_reset) begin
      active = 1'b0;
      stray_pending = 1'b0;
    end else if (stray_req || stray_pending) begin
      f_o_strb = 1'b1;
      f_o_data = 8'($urandom);
      stray_req = 1'b0;
      stray_pending = 1'b0;
    end else if (f_start) begin
      active = 1'b1;
      gap = 0;
      sent = 0;
    end else if (active) begin
      gap++;
      if (gap == period) begin
        gap = 0;
        f_o_strb = 1'b1;
        f_o_data = 8'($urandom);
        exp_q.push_back('{cyc + 1, 16'(sent), f_o_data});
        sent++;
        if (sent == limit) begin
          active = 1'b0;
          stray_pending = stray_after;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (f_h_write) hw_q.push_back('{cyc, 16'(f_h_idx), f_h_data});
    if (f_start) start_q.push_back(cyc);
    if (wr_en) wr_q.push_back('{cyc, wr_addr, wr_data});
    if (done) begin
      done_q.push_back(cyc);
      busy_at_done = busy;
      busy_before_done = busy_prev;
    end
    if (err && !err_prev) err_rise = cyc;
    err_prev = err;
    busy_prev = busy;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout observed=hang required=finish");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_default_coefs();
    for (int i = 0; i < 9; i++) begin
      coef[i] = (i == 4) ? 8'h20 : ((i % 2) == 1) ? 8'h10 : 8'h08;
    end
  endtask

  task automatic clear_logs();
    hw_q.delete();
    wr_q.delete();
    exp_q.delete();
    start_q.delete();
    done_q.delete();
    err_rise = -1;
  endtask

  task automatic check_idle_outputs(input string pfx);
    check_output({pfx, "_busy"}, busy, 0);
    check_output({pfx, "_done"}, done, 0);
    check_output({pfx, "_err"}, err, 0);
    check_output({pfx, "_f_start"}, f_start, 0);
    check_output({pfx, "_f_h_write"}, f_h_write, 0);
    check_output({pfx, "_f_h_idx"}, f_h_idx, 0);
    check_output({pfx, "_f_h_data"}, f_h_data, 0);
    check_output({pfx, "_wr_en"}, wr_en, 0);
    check_output({pfx, "_wr_addr"}, wr_addr, 0);
    check_output({pfx, "_wr_data"}, wr_data, 0);
  endtask

  // One frame: go (optionally with a same-cycle tap-8 write), then check the whole event log.
  task automatic apply_stimulus(input int lim, input int per, input bit expect_err,
                                input bit poke, input bit stray_d, input bit with_we);
    int k;
    int budget;
    int n_wr;
    clear_logs();
    limit = lim;
    period = per;
    stray_after = stray_d;
    if (with_we) begin
      cfg_we = 1'b1;
      cfg_idx = 4'd8;
      cfg_data = 8'($urandom);
      coef[8] = cfg_data;
    end
    go = 1'b1;
    k = cyc + 1;
    tick();
    go = 1'b0;
    cfg_we = 1'b0;
    budget = 0;
    while (done_q.size() == 0 && err_rise < 0 && budget < BUDGET) begin
      if (poke && cyc == k + 20) begin
        cfg_we = 1'b1;
        cfg_idx = 4'd0;
        cfg_data = 8'h77;
        go = 1'b1;
      end else begin
        cfg_we = 1'b0;
        go = 1'b0;
      end
      tick();
      budget++;
    end
    cfg_we = 1'b0;
    go = 1'b0;
    check_output("frame_ends", budget < BUDGET, 1);
    repeat (3) tick();

    check_output("hw_count", hw_q.size(), 9);
    for (int i = 0; i < 9 && i < hw_q.size(); i++) begin
      check_output($sformatf("hw_idx%0d", i), hw_q[i].a, i);
      check_output($sformatf("hw_data%0d", i), hw_q[i].d, coef[i]);
      check_output($sformatf("hw_cyc%0d", i), hw_q[i].cyc, k + 1 + i);
    end
    check_output("start_count", start_q.size(), 1);
    if (start_q.size() > 0) check_output("start_cyc", start_q[0], k + 10);

    n_wr = expect_err ? lim : N_PIX;
    check_output("wr_count", wr_q.size(), n_wr);
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
      check_output($sformatf("wr_addr%0d", i), wr_q[i].a, i);
      check_output($sformatf("wr_data%0d", i), wr_q[i].d, exp_q[i].d);
      check_output($sformatf("wr_cyc%0d", i), wr_q[i].cyc, exp_q[i].cyc);
    end

    if (!expect_err) begin
      check_output("done_count", done_q.size(), 1);
      if (done_q.size() > 0 && exp_q.size() > 0) begin
        check_output("done_cyc", done_q[0], exp_q[exp_q.size() - 1].cyc);
        check_output("busy_at_done", busy_at_done, 0);
        check_output("busy_before_done", busy_before_done, 1);
      end
      check_output("err_after_frame", err, 0);
    end else begin
      check_output("done_on_err", done_q.size(), 0);
      if (exp_q.size() > 0) begin
        check_output("err_rise_cyc", err_rise, exp_q[exp_q.size() - 1].cyc + TIMEOUT);
      end
      check_output("err_sticky", err, 1);
      check_output("busy_in_err", busy, 0);
    end
    check_output("busy_after_frame", busy, 0);
  endtask

  initial begin
    set_default_coefs();
    #1 n_reset = 1'b0;
    #2;
    check_idle_outputs("reset");
    tick();
    tick();
    n_reset = 1'b1;
    tick();
    check_idle_outputs("idle");

    $display("[TB] frame with default kernel, strobe every 12 cycles");
    apply_stimulus(N_PIX, 12, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] tap 4 rewrite, out-of-range tap 9, tap 8 written with go");
    cfg_we = 1'b1;
    cfg_idx = 4'd4;
    cfg_data = 8'h40;
    coef[4] = 8'h40;
    tick();
    cfg_idx = 4'd9;
    cfg_data = 8'h55;
    tick();
    cfg_we = 1'b0;
    tick();
    apply_stimulus(N_PIX, int'($urandom_range(1, 20)), 1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] cfg write and go while running");
    apply_stimulus(N_PIX, int'($urandom_range(3, 20)), 1'b0, 1'b1, 1'b0, 1'b0);

    $display("[TB] filter stalls after 5 strobes");
    apply_stimulus(5, int'($urandom_range(1, 20)), 1'b1, 1'b0, 1'b0, 1'b0);
    clear_logs();
    go = 1'b1;
    cfg_we = 1'b1;
    cfg_idx = 4'd1;
    cfg_data = 8'($urandom);
    coef[1] = cfg_data;
    tick();
    go = 1'b0;
    cfg_we = 1'b0;
    repeat (15) tick();
    check_output("err_go_hw", hw_q.size(), 0);
    check_output("err_go_wr", wr_q.size(), 0);
    check_output("err_hold", err, 1);
    check_output("err_busy", busy, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_output("err_cleared", err, 0);
    check_output("err_cleared_busy", busy, 0);

    $display("[TB] stray strobes in IDLE and DONE");
    clear_logs();
    stray_req = 1'b1;
    repeat (3) tick();
    check_output("stray_idle_wr", wr_q.size(), 0);
    apply_stimulus(N_PIX, int'($urandom_range(1, 20)), 1'b0, 1'b0, 1'b1, 1'b0);
    stray_after = 1'b0;

    $display("[TB] reset during RUN");
    clear_logs();
    limit = N_PIX;
    period = int'($urandom_range(2, 12));
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int b = 0; b < BUDGET && wr_q.size() < 7; b++) tick();
    check_output("mid_run_writes", wr_q.size() >= 7, 1);
    check_output("mid_run_busy", busy, 1);
    n_reset = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    tick();
    tick();
    n_reset = 1'b1;
    set_default_coefs();
    tick();
    apply_stimulus(N_PIX, int'($urandom_range(1, 20)), 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/filter2d_ctrl.md
Name: filter2d_ctrl

Overview:
- Sequencer in front of filter2d_op. Holds host-programmed 3x3 coefficients in shadow registers.
- On a host `go`, it downloads the coefficients into the filter, pulses the filter's start and collects WIDTH*WIDTH result strobes into an output frame buffer.
- Reports completion with `done`, or a stall with `err`. It is the only driver of the filter's start and h_* configuration ports.

Parameters:
- WIDTH, 256, image side in pixels (2..256). The frame holds WIDTH*WIDTH pixels.
- TIMEOUT, 64, maximum cycles allowed between consecutive filter strobes while running (>12).

Ports:
- clk  in  1  clock
- n_reset  in  1  asynchronous active-low reset
- cfg_we  in  1  host coefficient write strobe
- cfg_idx  in  4  coefficient index 0..8
- cfg_data  in  8  signed coefficient value
- go  in  1  start-frame request, single-cycle pulse
- err_clr  in  1  clears the error state
- busy  out  1  frame in progress (LOAD/START/RUN)
- done  out  1  one-cycle frame-complete pulse
- err  out  1  sticky watchdog error
- f_start  out  1  filter start pulse
- f_h_write  out  1  filter coefficient write
- f_h_idx  out  4  filter coefficient index
- f_h_data  out  8  filter coefficient data
- f_o_strb  in  1  filter result strobe
- f_o_data  in  8  filter result pixel
- wr_en  out  1  output buffer write enable
- wr_addr  out  16  output buffer address
- wr_data  out  8  output buffer data

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low (clk, n_reset).
  - All outputs are registered and reset to 0. The state resets to IDLE.
- Shadow coefficients:
  - Reset values, indices 0..8: 0x08, 0x10, 0x08, 0x10, 0x20, 0x10, 0x08, 0x10, 0x08. These equal the filter's own reset set.
  - A `cfg_we` write is accepted only in IDLE or ERR.
  - `cfg_we` is ignored while busy or when cfg_idx > 8. No other effect.
- FSM states: IDLE, LOAD, START, RUN, DONE, ERR.
- IDLE:
  - `go` sampled high at edge k -> LOAD.
  - `go` in any other state is ignored.
- LOAD:
  - 4-bit counter runs 0..8.
  - f_h_write=1, f_h_idx=counter and f_h_data=shadow[counter] in cycles k+1..k+9 (9 cycles, indices ascending). Then -> START.
- START:
  - f_start=1 for exactly one cycle (k+10). Clears the pixel counter and the watchdog. Then -> RUN.
- RUN:
  - Each f_o_strb=1 at cycle m gives wr_en=1, wr_addr=pixel count, wr_data=f_o_data in cycle m+1. The pixel count then increments.
  - After the strobe that makes the count equal WIDTH*WIDTH -> DONE.
- DONE:
  - done=1 for one cycle, aligned with the final wr_en cycle. Then -> IDLE.
- busy:
  - busy=1 exactly in the cycles where the state is LOAD, START or RUN.
- Watchdog:
  - In RUN, a 16-bit counter increments each cycle and resets on each f_o_strb.
  - Reaching TIMEOUT -> ERR: err=1 (sticky), busy=0, no further writes.
- ERR:
  - Stays until `err_clr`, then -> IDLE with err=0.
  - `go` is ignored in ERR. The filter is not aborted (it has no abort); software must reset it.
- Stray strobes:
  - f_o_strb outside RUN is ignored: no write, no counter change.
- Address arithmetic:
  - wr_addr is a 16-bit count; the maximum count 65536 needs a 17-bit internal counter.
  - The terminal compare is performed at 17 bits, so WIDTH=256 terminates correctly.
- Simultaneous events:
  - If f_o_strb and the timeout coincide, the strobe wins: it is written and the watchdog reloads.
  - `cfg_we` together with `go` in IDLE: the write is applied first, so the new value is downloaded.
- Reset mid-operation:
  - Asynchronous return to IDLE. Shadow coefficients reload their defaults. All outputs go to 0 immediately.

Decomposition:
- Shared package filter2d_pkg holds:
  - The state enum.
  - The default coefficient constants, used by both filter2d_op and this block.
  - N_TAPS=9.
- One natural sub-module: filter2d_watchdog, a loadable cycle counter with a timeout flag.

Test Plan:
- Reset then `go` with WIDTH=4, filter model strobing every 12 cycles -> f_h_write at k+1..k+9 carrying 08,10,08,10,20,10,08,10,08; f_start at k+10; 16 writes to addresses 0..15; done coincides with addr 15; busy drops the same cycle.
- Write cfg_idx=4 data=0x40 and idx=9 data=0x55, then `go` -> idx 4 downloads 0x40; idx 9 write has no effect; all other taps stay at default.
- `cfg_we` idx=0 and `go` during RUN -> the shadow stays 0x08; no second download; the frame completes normally.
- Filter model stops after 5 strobes, TIMEOUT=64 -> err=1 64 cycles after the 5th strobe; no further wr_en; `err_clr` returns to IDLE; the next `go` succeeds.
- f_o_strb pulsed in IDLE and in DONE -> no wr_en; the next frame starts writing at addr 0.
- n_reset asserted mid-RUN (after strobe 7) -> all outputs 0 asynchronously; after release, `go` downloads default coefficients and writes from addr 0.
